// File: rtl/memc_deskew_if.sv
// memc_deskew handshake bundle: skewed C lanes in, aligned tile rows out.
// master drives the array side and consumes rows; slave is the deskew block.
interface memc_deskew_if #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                              cin_vld;
  logic signed [DIM-1:0][BITS_C-1:0] Cin;
  logic                              out_vld;
  logic                              out_rdy;
  logic signed [DIM-1:0][BITS_C-1:0] out_data;
  logic        [AW-1:0]              out_idx;

  modport master (
    output cin_vld, Cin, out_rdy,
    input  out_vld, out_data, out_idx
  );

  modport slave (
    input  cin_vld, Cin, out_rdy,
    output out_vld, out_data, out_idx
  );
endinterface

// File: rtl/memc_deskew.sv
// Deskews systolic C lanes into a DIMxDIM tile and drains it row by row.
// `define MEMC_TRANSPOSE_EN to drain columns instead of rows.
module memc_deskew #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  memc_deskew_if.slave  bus,
  output logic          busy,
  output logic          ovf
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [AW-1:0] LAST = AW'(DIM - 1);

  typedef logic signed [DIM-1:0][BITS_C-1:0] row_t;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t         state, state_n;
  logic [AW-1:0]  wr_ptr, wr_n;
  logic [AW-1:0]  rd_ptr, rd_n;
  logic           ovf_n;
  logic           we;
  logic [DIM-2:0] vpipe;
  logic           aligned_vld;
  row_t           aligned;
  row_t           tile [DIM];
  row_t           dout;

  // lane k waits DIM-1-k cycles so all lanes meet lane DIM-1
  for (genvar k = 0; k < DIM; k++) begin : g_lane
    localparam int D = DIM - 1 - k;
    if (D == 0) begin : g_pass
      assign aligned[k] = bus.Cin[k];
    end else begin : g_dl
      logic [D-1:0][BITS_C-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= '0;
        end else if (clr) begin
          sr <= '0;
        end else begin
          sr[0] <= bus.Cin[k];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[k] = sr[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else if (clr) begin
      vpipe <= '0;
    end else begin
      vpipe <= (vpipe << 1) | (DIM-1)'(bus.cin_vld);
    end
  end

  assign aligned_vld = vpipe[DIM-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      ovf    <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    ovf_n   = ovf;
    we      = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (aligned_vld) begin
          we      = 1'b1;
          state_n = COLLECT;
          wr_n    = AW'(1);
        end
      end
      (state == COLLECT): begin
        if (aligned_vld) begin
          we = 1'b1;
          if (wr_ptr == LAST) begin
            state_n = DRAIN;
            wr_n    = '0;
          end else begin
            wr_n = wr_ptr + 1'b1;
          end
        end
      end
      (state == DRAIN): begin
        // no room while draining, including the final transfer cycle
        if (aligned_vld) ovf_n = 1'b1;
        if (bus.out_rdy) begin
          if (rd_ptr == LAST) begin
            state_n = IDLE;
            rd_n    = '0;
          end else begin
            rd_n = rd_ptr + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) tile[wr_ptr] <= aligned;
  end

  always_comb begin
    dout = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < DIM; j++) begin
`ifdef MEMC_TRANSPOSE_EN
        dout[j] = tile[j][rd_ptr];
`else
        dout[j] = tile[rd_ptr][j];
`endif
      end
    end
  end

  assign bus.out_vld  = (state == DRAIN);
  assign bus.out_data = dout;
  assign bus.out_idx  = rd_ptr;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_memc_deskew.sv
// Randomized bench for memc_deskew with a queue-based tile model.
// Build with MEMC_TRANSPOSE_EN defined to check the column readout.
module tb_memc_deskew;
  localparam int DIM    = 4;
  localparam int BITS_C = 16;
  localparam int N      = 2048;
  localparam int LAT    = DIM - 1;

  typedef logic [DIM-1:0][BITS_C-1:0] row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;
  logic busy;
  logic ovf;

  memc_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  row_t rows [N];
  bit   vld  [N];
  bit   rdy  [N];
  bit   clrv [N];
  bit   rstv [N];

  int   n     = 0;
  int   flush = 0;
  int   nchk  = 0;
  int   nerr  = 0;
  int   lat;
  bit   seen_vld;

  row_t tq[$];
  bit   drn   = 1'b0;
  int   rd    = 0;
  bit   m_ovf = 1'b0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s slot %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic row_t exp_data();
    row_t r = '0;
    if (drn) begin
      for (int j = 0; j < DIM; j++) begin
`ifdef MEMC_TRANSPOSE_EN
        r[j] = tq[j][rd];
`else
        r[j] = tq[rd][j];
`endif
      end
    end
    return r;
  endfunction

  task automatic m_reset();
    tq.delete();
    drn   = 1'b0;
    rd    = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit al = 1'b0;
    if (rstv[n] || clrv[n]) begin
      m_reset();
      flush = n + 1;
      return;
    end
    if (n - LAT >= flush) al = vld[n-LAT];
    if (drn) begin
      if (al) m_ovf = 1'b1;
      if (rdy[n]) begin
        rd++;
        if (rd == DIM) begin
          drn = 1'b0;
          rd  = 0;
          tq.delete();
        end
      end
    end else if (al) begin
      tq.push_back(rows[n-LAT]);
      if (tq.size() == DIM) drn = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    seen_vld = bus.out_vld;
    chk("out_vld", 64'(bus.out_vld), 64'(drn));
    chk("out_idx", 64'(bus.out_idx), 64'(rd));
    chk("out_data", 64'(bus.out_data), 64'(exp_data()));
    chk("busy", 64'(busy), 64'(drn || tq.size() != 0));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    rst_n       = !rstv[n];
    clr         = clrv[n];
    bus.cin_vld = vld[n];
    bus.out_rdy = rdy[n];
    for (int k = 0; k < DIM; k++)
      bus.Cin[k] = (n >= k) ? rows[n-k][k] : '0;
    if (rstv[n]) begin
      #1;
      chk("rst_vld", 64'(bus.out_vld), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
      chk("rst_idx", 64'(bus.out_idx), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
    end
    @(posedge clk);
    model_edge();
    n++;
  endtask

  task automatic run(int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic pat_row(int slot, int r);
    for (int k = 0; k < DIM; k++) rows[slot][k] = BITS_C'(r * 16 + k);
    vld[slot] = 1'b1;
  endtask

  initial begin
    int b;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < DIM; k++) rows[i][k] = BITS_C'($urandom);
      vld[i]  = 1'b0;
      rdy[i]  = 1'b1;
      clrv[i] = 1'b0;
      rstv[i] = 1'b0;
    end
    bus.cin_vld = 1'b0;
    bus.out_rdy = 1'b0;
    bus.Cin     = '0;

    #1 rst_n = 1'b0;
    #20;
    chk("init_vld", 64'(bus.out_vld), 64'd0);
    chk("init_data", 64'(bus.out_data), 64'd0);
    chk("init_idx", 64'(bus.out_idx), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_ovf", 64'(ovf), 64'd0);

    // two rows collected, then async reset mid-COLLECT
    b = n;
    pat_row(b, 9);
    pat_row(b + 1, 10);
    rstv[b+6] = 1'b1;
    run(9);

    // aligned stream, consumer always ready
    b   = n;
    lat = -1;
    for (int r = 0; r < DIM; r++) pat_row(b + r, r);
    for (int i = 0; i < 16; i++) begin
      step();
      if (seen_vld && lat < 0) lat = i;
    end
    chk("latency", 64'(lat), 64'(2 * DIM - 1));

    // backpressure at the start of DRAIN
    b = n;
    for (int r = 0; r < DIM; r++) pat_row(b + r, r);
    for (int i = 0; i < 12; i++) rdy[b+i] = 1'b0;
    run(20);

    // fifth row lands while the tile is full, then clr
    b = n;
    for (int i = 0; i < DIM + 1; i++) vld[b+i] = 1'b1;
    for (int i = 0; i < 15; i++) rdy[b+i] = 1'b0;
    clrv[b+20] = 1'b1;
    run(24);

    // gapped input
    b = n;
    pat_row(b, 0);
    pat_row(b + 3, 1);
    pat_row(b + 4, 2);
    pat_row(b + 9, 3);
    run(22);

    // random traffic with occasional clr and reset
    b = n;
    for (int i = b; i < b + 900; i++) begin
      vld[i]  = ($urandom % 2) == 0;
      rdy[i]  = ($urandom % 4) != 0;
      clrv[i] = ($urandom % 120) == 0;
      rstv[i] = ($urandom % 250) == 0;
    end
    run(900);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
